// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle for the instruction fetch unit: instruction-memory port, redirect input
// and the decode-facing instruction stream.
interface instruction_fetch_unit_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Decode handshake: an entry transfers on a cycle where out_valid and out_ready are
  // both high; out_valid never waits on out_ready, and out_inst/out_pc read 0 while
  // out_valid is low.
  logic [31:0]   imem_addr;
  logic [31:0]   imem_inst;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [31:0]   out_pc;
  logic [CW-1:0] fifo_count;

  modport master (
    output imem_addr,
    input  imem_inst,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output fifo_count
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  fifo_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: walks the fetch PC over a zero-latency instruction memory and
// queues {pc, inst} pairs in a small prefetch FIFO for decode; redirects flush and refetch.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  instruction_fetch_unit_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   inst_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem   [FIFO_DEPTH];

  logic          head_valid;
  logic          pop;
  logic          push;
  logic [31:0]   redirect_target;

  // Masking with ~3 keeps every redirect_pc bit in use while discarding the low two.
  assign redirect_target = bus.redirect_pc & ~32'h3;

  assign head_valid = (count != '0) && !bus.redirect_valid;
  assign pop        = head_valid && bus.out_ready;
  assign push       = !rst && !bus.redirect_valid && ((count < CW'(FIFO_DEPTH)) || pop);

  assign bus.imem_addr  = rst ? RESET_PC : fetch_pc;
  assign bus.out_valid  = head_valid;
  assign bus.out_inst   = head_valid ? inst_mem[rd_ptr] : 32'h0;
  assign bus.out_pc     = head_valid ? pc_mem[rd_ptr]   : 32'h0;
  assign bus.fifo_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= redirect_target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= bus.imem_inst;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_instruction_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [31:0] mem [256];
  logic [63:0] exp_q[$];
  logic [31:0] m_pc = RESET_PC;

  instruction_fetch_unit_if #(.FIFO_DEPTH(DEPTH)) bus ();

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // 256-word memory aliased across the address space
  assign bus.imem_inst = mem[bus.imem_addr[9:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_for(input logic [31:0] p);
    return 32'h1000_0000 + ((p >> 2) & 32'hFF);
  endfunction

  // Scoreboard: compare outputs, then advance the queue model to the next cycle.
  always @(negedge clk) begin
    logic        e_valid;
    logic [31:0] e_pc, e_inst, e_addr;
    e_valid = (exp_q.size() != 0) && !bus.redirect_valid;
    e_pc    = e_valid ? exp_q[0][63:32] : 32'h0;
    e_inst  = e_valid ? exp_q[0][31:0]  : 32'h0;
    e_addr  = rst ? RESET_PC : m_pc;
    if (chk_en) begin
      check("model_out_valid", 32'(bus.out_valid), 32'(e_valid));
      check("model_out_pc", bus.out_pc, e_pc);
      check("model_out_inst", bus.out_inst, e_inst);
      check("model_imem_addr", bus.imem_addr, e_addr);
      check("model_fifo_count", 32'(bus.fifo_count), 32'(exp_q.size()));
    end
    if (rst) begin
      exp_q.delete();
      m_pc = RESET_PC;
    end else if (bus.redirect_valid) begin
      exp_q.delete();
      m_pc = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      if (e_valid && bus.out_ready) void'(exp_q.pop_front());
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back({m_pc, inst_for(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_head(input string name, input logic [31:0] pc);
    @(negedge clk);
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_pc"}, bus.out_pc, pc);
    check({name, "_inst"}, bus.out_inst, inst_for(pc));
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] ready_pat;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    rst = 1'b1;
    step();
    step();
    chk_en = 1'b1;

    // 1: release reset with decode always ready
    rst = 1'b0;
    @(negedge clk);
    check("t1_valid_release_cycle", 32'(bus.out_valid), 32'd0);
    check("t1_addr_release_cycle", bus.imem_addr, 32'h0);
    step();
    @(negedge clk);
    check("t1_first_pc", bus.out_pc, 32'h0);
    check("t1_first_inst", bus.out_inst, 32'h1000_0000);
    for (int k = 1; k <= 6; k++) begin
      step();
      expect_head("t1_stream", 32'(4 * k));
    end

    // 2/3: stall until full, then drain while refilling
    step();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    step();
    rst = 1'b0;
    repeat (10) step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t2_count_saturated", 32'(bus.fifo_count), 32'd4);
    check("t2_addr_held", bus.imem_addr, 32'h10);
    check("t2_head_pc", bus.out_pc, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      step();
      expect_head("t2_drain", 32'(4 * k));
      check("t3_count_full", 32'(bus.fifo_count), 32'd4);
      check("t3_addr_advance", bus.imem_addr, 32'h10 + 32'(4 * k));
    end

    // 4: redirect with three entries queued
    step();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    step();
    rst = 1'b0;
    repeat (3) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0043;
    @(negedge clk);
    check("t4_count_before", 32'(bus.fifo_count), 32'd3);
    check("t4_valid_redirect_cycle", 32'(bus.out_valid), 32'd0);
    step();
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t4_valid_after", 32'(bus.out_valid), 32'd0);
    check("t4_addr_target", bus.imem_addr, 32'h40);
    check("t4_count_flushed", 32'(bus.fifo_count), 32'd0);
    step();
    @(negedge clk);
    check("t4_head_pc", bus.out_pc, 32'h40);
    check("t4_head_inst", bus.out_inst, 32'h1000_0010);
    step();
    expect_head("t4_next", 32'h44);

    // back-to-back redirects: only the last target is fetched
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    step();
    redirect(32'h200);
    @(negedge clk);
    check("b2b_valid_gap", 32'(bus.out_valid), 32'd0);
    check("b2b_addr", bus.imem_addr, 32'h200);
    step();
    @(negedge clk);
    check("b2b_head_pc", bus.out_pc, 32'h200);
    check("b2b_head_inst", bus.out_inst, 32'h1000_0080);

    // 5: fetch PC wrap across 2^32
    step();
    redirect(32'hFFFF_FFF8);
    step();
    @(negedge clk);
    check("t5_pc0", bus.out_pc, 32'hFFFF_FFF8);
    check("t5_inst0", bus.out_inst, 32'h1000_00FE);
    step();
    @(negedge clk);
    check("t5_pc1", bus.out_pc, 32'hFFFF_FFFC);
    check("t5_inst1", bus.out_inst, 32'h1000_00FF);
    step();
    @(negedge clk);
    check("t5_pc2", bus.out_pc, 32'h0000_0000);
    check("t5_inst2", bus.out_inst, 32'h1000_0000);

    // irregular decode backpressure, checked by the model
    ready_pat = 16'b1011_0010_1110_0101;
    for (int k = 0; k < 16; k++) begin
      step();
      bus.out_ready = ready_pat[k];
    end

    // 6: reset while full with decode ready
    step();
    bus.out_ready = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t6_count_full", 32'(bus.fifo_count), 32'd4);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_valid_after_rst", 32'(bus.out_valid), 32'd0);
    check("t6_count_after_rst", 32'(bus.fifo_count), 32'd0);
    check("t6_addr_after_rst", bus.imem_addr, RESET_PC);
    step();
    expect_head("t6_restart", RESET_PC);
    repeat (3) step();

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
